seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// =============================================================================
// seg7_scan_decoder
//   Recovers BCD digits from a multiplexed, active-low 8-digit 7-segment bus.
// Revision: 1.0
// =============================================================================
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  iAn,
    input  logic [6:0]  iSeg,
    output logic [31:0] oDigits,
    output logic [7:0]  oValid,
    output logic        oUpdate,
    output logic        oFrameDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0]  STABLE_CNT = 4'(STABLE_CYCLES);
    localparam logic [14:0] PAIR_RST   = {8'hFF, 7'h7F};

    state_t      state_q;
    logic [14:0] pair_q;
    logic [3:0]  count_q, count_d;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] digits_q;
    logic [7:0]  valid_q;
    logic        update_q;
    logic        frame_q;

    logic [14:0] w_pair;
    logic        w_single;
    logic [2:0]  w_pos;
    logic [3:0]  w_zeros;
    logic [3:0]  w_dec_val;
    logic        w_dec_legal;
    logic        w_frame_full;

    assign w_pair = {iAn, iSeg};

    always_comb begin
        w_zeros = 4'd0;
        w_pos   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!iAn[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_pos   = 3'(i);
            end
        end
    end

    assign w_single = (w_zeros == 4'd1);

    always_comb begin
        w_dec_legal = 1'b1;
        case (iSeg)
            7'b1000000: w_dec_val = 4'd0;
            7'b1111001: w_dec_val = 4'd1;
            7'b0100100: w_dec_val = 4'd2;
            7'b0110000: w_dec_val = 4'd3;
            7'b0011001: w_dec_val = 4'd4;
            7'b0010010: w_dec_val = 4'd5;
            7'b0000010: w_dec_val = 4'd6;
            7'b1111000: w_dec_val = 4'd7;
            7'b0000000: w_dec_val = 4'd8;
            7'b0010000: w_dec_val = 4'd9;
            default: begin
                w_dec_val   = 4'hF;
                w_dec_legal = 1'b0;
            end
        endcase
    end

    // Run length of identical single-select samples, saturating at the threshold
    always_comb begin
        if (w_single && (w_pair == pair_q)) begin
            count_d = (count_q >= STABLE_CNT) ? STABLE_CNT : count_q + 4'd1;
        end else begin
            count_d = w_single ? 4'd1 : 4'd0;
        end
    end

    assign seen_d       = seen_q | (8'd1 << w_pos);
    assign w_frame_full = (seen_d == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pair_q   <= PAIR_RST;
            count_q  <= 4'd0;
            seen_q   <= 8'd0;
            digits_q <= 32'hFFFF_FFFF;
            valid_q  <= 8'd0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            pair_q   <= w_pair;
            count_q  <= count_d;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_single) state_q <= TRACK;
                end
                TRACK: begin
                    if (!w_single) begin
                        state_q <= IDLE;
                    end else if (count_d == STABLE_CNT) begin
                        state_q                      <= HOLD;
                        digits_q[{w_pos, 2'b00} +: 4] <= w_dec_val;
                        valid_q[w_pos]               <= w_dec_legal;
                        update_q                     <= 1'b1;
                        frame_q                      <= w_frame_full;
                        seen_q                       <= w_frame_full ? 8'd0 : seen_d;
                    end
                end
                HOLD: begin
                    if (!w_single) begin
                        state_q <= IDLE;
                    end else if (w_pair != pair_q) begin
                        state_q <= TRACK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oDigits    = digits_q;
    assign oValid     = valid_q;
    assign oUpdate    = update_q;
    assign oFrameDone = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// tb_seg7_scan_decoder
//   Directed and randomized checks against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  iAn;
    logic [6:0]  iSeg;
    logic [31:0] oDigits;
    logic [7:0]  oValid;
    logic        oUpdate;
    logic        oFrameDone;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iAn        (iAn),
        .iSeg       (iSeg),
        .oDigits    (oDigits),
        .oValid     (oValid),
        .oUpdate    (oUpdate),
        .oFrameDone (oFrameDone)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int frame_cnt = 0;
    bit chk_en   = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Expected state after the next rising edge
    logic [3:0]  m_dig [8];
    logic [7:0]  m_valid;
    logic [7:0]  m_seen;
    logic        m_upd;
    logic        m_frame;
    logic [14:0] m_prev;
    int          m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_word();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) w[4*i +: 4] = m_dig[i];
        return w;
    endfunction

    task automatic model_step(input logic [7:0] an, input logic [6:0] seg, input logic rstn);
        int   zeros;
        int   pos;
        int   val;
        logic [14:0] pair;
        pair = {an, seg};
        if (!rstn) begin
            for (int i = 0; i < 8; i++) m_dig[i] = 4'hF;
            m_valid = 8'd0;
            m_seen  = 8'd0;
            m_upd   = 1'b0;
            m_frame = 1'b0;
            m_prev  = {8'hFF, 7'h7F};
            m_run   = 0;
            return;
        end
        zeros = 0;
        pos   = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; pos = i; end
        if (zeros == 1 && pair == m_prev) m_run++;
        else m_run = (zeros == 1) ? 1 : 0;
        m_prev  = pair;
        m_upd   = 1'b0;
        m_frame = 1'b0;
        if (m_run == STABLE) begin
            val = 15;
            for (int d = 0; d < 10; d++) if (seg_tab[d] == seg) val = d;
            m_dig[pos]   = 4'(val);
            m_valid[pos] = (val != 15);
            m_upd        = 1'b1;
            m_seen[pos]  = 1'b1;
            if (m_seen == 8'hFF) begin
                m_frame = 1'b1;
                m_seen  = 8'd0;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic rstn);
        iAn   = an;
        iSeg  = seg;
        rst_n = rstn;
        model_step(an, seg, rstn);
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
        repeat (n) drive(an, seg, 1'b1);
    endtask

    task automatic do_reset();
        drive(8'hFF, 7'h7F, 1'b0);
        drive(8'hFF, 7'h7F, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("digits", oDigits, m_word());
            check("valid", {24'd0, oValid}, {24'd0, m_valid});
            check("update", {31'd0, oUpdate}, {31'd0, m_upd});
            check("frame", {31'd0, oFrameDone}, {31'd0, m_frame});
            if (oUpdate) upd_cnt++;
            if (oFrameDone) frame_cnt++;
        end
    end

    initial begin
        int u0, f0, hl, kind;
        logic [7:0] an;
        logic [6:0] seg;
        rst_n = 1'b0;
        iAn   = 8'hFF;
        iSeg  = 7'h7F;
        @(negedge clk);
        do_reset();
        check("reset_digits", oDigits, 32'hFFFF_FFFF);
        check("reset_valid", {24'd0, oValid}, 32'd0);

        // Digit 2 on position 0: capture exactly at the fourth edge
        u0 = upd_cnt;
        hold(8'hFE, 7'b0100100, 3);
        check("d2_no_early_update", {31'd0, oUpdate}, 32'd0);
        hold(8'hFE, 7'b0100100, 1);
        check("d2_update_edge4", {31'd0, oUpdate}, 32'd1);
        check("d2_digit0", {28'd0, oDigits[3:0]}, 32'd2);
        check("d2_valid0", {31'd0, oValid[0]}, 32'd1);
        hold(8'hFE, 7'b0100100, 6);
        check("d2_single_pulse", upd_cnt - u0, 32'd1);

        // Pair abandoned after three edges
        do_reset();
        u0 = upd_cnt;
        hold(8'hFB, 7'b0011001, 3);
        drive(8'hFF, 7'h7F, 1'b1);
        check("short_hold_digit2", {28'd0, oDigits[11:8]}, 32'hF);
        check("short_hold_valid", {24'd0, oValid}, 32'd0);
        check("short_hold_no_update", upd_cnt - u0, 32'd0);

        // Full scan of digits 0..7
        do_reset();
        u0 = upd_cnt;
        f0 = frame_cnt;
        for (int i = 0; i < 8; i++) begin
            an = ~(8'd1 << i);
            hold(an, seg_tab[i], 6);
        end
        check("scan_updates", upd_cnt - u0, 32'd8);
        check("scan_frames", frame_cnt - f0, 32'd1);
        check("scan_digits", oDigits, 32'h7654_3210);
        check("scan_valid", {24'd0, oValid}, 32'h0000_00FF);

        // Illegal pattern on position 4
        do_reset();
        u0 = upd_cnt;
        hold(8'hEF, 7'b0101010, 5);
        check("illegal_digit4", {28'd0, oDigits[19:16]}, 32'hF);
        check("illegal_valid4", {31'd0, oValid[4]}, 32'd0);
        check("illegal_update", upd_cnt - u0, 32'd1);

        // Two anodes selected, then reset mid-capture
        do_reset();
        u0 = upd_cnt;
        hold(8'hFC, 7'h40, 10);
        check("multi_select_no_update", upd_cnt - u0, 32'd0);
        hold(8'hFD, 7'h79, 2);
        drive(8'hFD, 7'h79, 1'b0);
        check("rst_mid_digits", oDigits, 32'hFFFF_FFFF);
        check("rst_mid_valid", {24'd0, oValid}, 32'd0);
        check("rst_mid_update", {31'd0, oUpdate}, 32'd0);
        check("rst_mid_frame", {31'd0, oFrameDone}, 32'd0);
        hold(8'hFD, 7'h79, 3);
        check("post_rst_no_early", {31'd0, oUpdate}, 32'd0);
        hold(8'hFD, 7'h79, 1);
        check("post_rst_capture", {31'd0, oUpdate}, 32'd1);
        check("post_rst_digit1", {28'd0, oDigits[7:4]}, 32'd1);

        // Randomized scanning with glitches, blanks, illegal codes and resets
        for (int k = 0; k < 600; k++) begin
            kind = $urandom_range(0, 39);
            hl   = $urandom_range(1, 7);
            if (kind == 0) begin
                repeat ($urandom_range(1, 2)) drive(8'hFF, 7'h7F, 1'b0);
            end else if (kind < 4) begin
                an = (kind == 1) ? 8'hFF : 8'($urandom);
                seg = 7'($urandom);
                hold(an, seg, hl);
            end else begin
                an  = ~(8'd1 << $urandom_range(0, 7));
                seg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 9)];
                hold(an, seg, hl);
            end
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
